// File: rtl/mult_twiddle_ctrl_pkg.sv
// Shared definitions for the 2x2 twiddle-multiply sequencer: default FFT size,
// controller state encoding and a helper for the per-dimension group count.
package mult_twiddle_ctrl_pkg;

  localparam int unsigned N_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Groups per dimension: k1 and k2 each span 0 .. N/2-1.
  function automatic int unsigned half_n(input int unsigned n_log2);
    return (32'd1 << n_log2) / 32'd2;
  endfunction

endpackage

// File: rtl/mult_valid_pipe.sv
// Fixed-depth shift register carrying valid/last alongside the ROM read and
// multiplier pipeline; async clear drops any in-flight groups.
module mult_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] lst_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      lst_q[0] <= valid_i & last_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign last_o  = lst_q[DEPTH-1];

endmodule

// File: rtl/mult_twiddle_ctrl.sv
// Sequencer for the 2x2 twiddle-multiply stage: accepts (N/2)^2 groups per
// frame, drives twiddle ROM addresses, tracks pipeline latency and credits.
module mult_twiddle_ctrl
  import mult_twiddle_ctrl_pkg::*;
#(
  parameter int unsigned N_LOG2   = N_LOG2_DEF,
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned CREDITS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cap_en,
  output logic [N_LOG2-1:0] tw_addr_2,
  output logic [N_LOG2-1:0] tw_addr_3,
  output logic [N_LOG2-1:0] tw_addr_4,
  output logic              out_valid,
  output logic              out_last,
  input  logic              credit_ret,
  output logic              err
);

  localparam int unsigned       HALF     = half_n(N_LOG2);
  localparam int unsigned       CW       = $clog2(CREDITS + 1);
  localparam logic [N_LOG2-1:0] K_MAX    = N_LOG2'(HALF - 1);
  localparam logic [CW-1:0]     CRED_MAX = CW'(CREDITS);

  state_e            state_q;
  logic [N_LOG2-1:0] k1_q;
  logic [N_LOG2-1:0] k2_q;
  logic [CW-1:0]     cred_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              last_grp;
  logic              start_ok;
  logic              err_set;
  logic [N_LOG2:0]   k_sum;
  logic              pipe_valid;
  logic              pipe_last;

  always_comb begin
    in_ready = (state_q == ST_RUN) && (cred_q != '0);
    accept   = in_valid & in_ready;
    last_grp = (k1_q == K_MAX) && (k2_q == K_MAX);
    start_ok = start && (state_q == ST_IDLE);
    // A return that coincides with an accept is a net no-op, never an overflow.
    err_set  = (credit_ret && !accept && (cred_q == CRED_MAX)) ||
               (start && (state_q != ST_IDLE));
    k_sum    = {1'b0, k1_q} + {1'b0, k2_q};
  end

  assign cap_en    = accept;
  assign tw_addr_2 = k2_q;
  assign tw_addr_3 = k1_q;
  assign tw_addr_4 = N_LOG2'(k_sum);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = pipe_valid;
  assign out_last  = pipe_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k1_q    <= '0;
      k2_q    <= '0;
      cred_q  <= CRED_MAX;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_set | (err_q & ~start_ok);

      if (accept && !credit_ret) begin
        cred_q <= cred_q - CW'(1);
      end else if (credit_ret && !accept && (cred_q != CRED_MAX)) begin
        cred_q <= cred_q + CW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            k1_q    <= '0;
            k2_q    <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (k2_q == K_MAX) begin
              k2_q <= '0;
              k1_q <= last_grp ? '0 : k1_q + N_LOG2'(1);
            end else begin
              k2_q <= k2_q + N_LOG2'(1);
            end
            if (last_grp) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The final group is the youngest in the chain, so its exit empties it.
          if (pipe_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mult_valid_pipe #(
    .DEPTH(ROM_LAT + MULT_LAT)
  ) u_valid_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (accept),
    .last_i  (last_grp),
    .valid_o (pipe_valid),
    .last_o  (pipe_last)
  );

endmodule

// File: tb/tb_mult_twiddle_ctrl.sv
// Directed bench for mult_twiddle_ctrl with default parameters (8x8 frame,
// 3-cycle output latency, 4 credits).
module tb_mult_twiddle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic       cap_en;
  logic [2:0] tw_addr_2;
  logic [2:0] tw_addr_3;
  logic [2:0] tw_addr_4;
  logic       out_valid;
  logic       out_last;
  logic       credit_ret;
  logic       err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mult_twiddle_ctrl #(
    .N_LOG2   (3),
    .MULT_LAT (2),
    .ROM_LAT  (1),
    .CREDITS  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cap_en     (cap_en),
    .tw_addr_2  (tw_addr_2),
    .tw_addr_3  (tw_addr_3),
    .tw_addr_4  (tw_addr_4),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .credit_ret (credit_ret),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_addr(input int unsigned grp);
    check_eq("tw_addr_2", 32'(tw_addr_2), grp % 4);
    check_eq("tw_addr_3", 32'(tw_addr_3), grp / 4);
    check_eq("tw_addr_4", 32'(tw_addr_4), (grp % 4) + (grp / 4));
  endtask

  // Full frame with credits returned alongside each accept; optionally gapped 1/0.
  task automatic run_frame(input bit gapped);
    int unsigned grp;
    int          last_c;
    bit          v;
    bit          ov;
    grp    = 0;
    last_c = gapped ? 33 : 18;
    start  = 1'b1;
    next_cycle();
    start  = 1'b0;
    for (int c = 0; c < last_c + 4; c++) begin
      v  = gapped ? (c < 32 && (c % 2) == 0) : (c < 16);
      ov = (c >= 3) && (gapped ? ((c - 3) < 32 && ((c - 3) % 2) == 0) : ((c - 3) < 16));
      in_valid   = v;
      credit_ret = v;
      sample();
      check_eq("cap_en", 32'(cap_en), 32'(v));
      if (v) begin
        check_eq("in_ready", 32'(in_ready), 1);
        check_addr(grp);
        grp++;
      end
      check_eq("out_valid", 32'(out_valid), 32'(ov));
      check_eq("out_last", 32'(out_last), 32'(c == last_c));
      check_eq("done", 32'(done), 32'(c == last_c + 1));
      check_eq("busy", 32'(busy), 32'(c <= last_c));
      next_cycle();
    end
    in_valid   = 1'b0;
    credit_ret = 1'b0;
    sample();
    check_eq("err_after_frame", 32'(err), 0);
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] vin;
    logic [12:0] vret;
    logic [12:0] vst;
    logic [12:0] rdy;
    int unsigned grp;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; credit_ret = 1'b0;
    repeat (2) next_cycle();
    sample();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_cap_en", 32'(cap_en), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_tw2", 32'(tw_addr_2), 0);
    check_eq("rst_tw4", 32'(tw_addr_4), 0);
    next_cycle();
    rst = 1'b0;

    // in_valid while idle is neither consumed nor an error
    in_valid = 1'b1;
    sample();
    check_eq("idle_in_ready", 32'(in_ready), 0);
    check_eq("idle_cap_en", 32'(cap_en), 0);
    next_cycle();
    in_valid = 1'b0;
    sample();
    check_eq("idle_err", 32'(err), 0);
    next_cycle();

    run_frame(1'b0);
    run_frame(1'b1);

    // Credit starvation, simultaneous accept/return, start during RUN
    vin  = 13'h07FF;
    vret = 13'h0740;
    vst  = 13'h0800;
    rdy  = 13'h1E8F;
    grp  = 0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid   = vin[c];
      credit_ret = vret[c];
      start      = vst[c];
      sample();
      check_eq("starve_in_ready", 32'(in_ready), 32'(rdy[c]));
      check_eq("starve_cap_en", 32'(cap_en), 32'(vin[c] & rdy[c]));
      if (vin[c] && rdy[c]) begin
        check_addr(grp);
        grp++;
      end
      next_cycle();
    end
    in_valid = 1'b0; credit_ret = 1'b0; start = 1'b0;
    sample();
    check_eq("run_start_err", 32'(err), 1);
    check_eq("run_start_busy", 32'(busy), 1);
    check_eq("run_start_ready", 32'(in_ready), 1);
    check_addr(7);
    check_eq("inflight_valid_a", 32'(out_valid), 1);
    next_cycle();
    sample();
    check_eq("inflight_valid_b", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_out_valid", 32'(out_valid), 0);
    check_eq("arst_err", 32'(err), 0);
    check_eq("arst_in_ready", 32'(in_ready), 0);
    check_eq("arst_tw3", 32'(tw_addr_3), 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      check_eq("abort_no_done", 32'(done), 0);
      check_eq("abort_no_valid", 32'(out_valid), 0);
      next_cycle();
    end

    // Credit overflow in IDLE, start clears err, overflow in RUN saturates at 4
    credit_ret = 1'b1;
    next_cycle();
    credit_ret = 1'b0;
    sample();
    check_eq("ovf_idle_err", 32'(err), 1);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    credit_ret = 1'b1;
    sample();
    check_eq("start_clears_err", 32'(err), 0);
    check_eq("restart_busy", 32'(busy), 1);
    check_eq("restart_ready", 32'(in_ready), 1);
    check_addr(0);
    next_cycle();
    credit_ret = 1'b0;
    in_valid = 1'b1;
    sample();
    check_eq("ovf_run_err", 32'(err), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) sample();
      check_eq("sat_in_ready", 32'(in_ready), 32'(i < 4));
      if (i < 4) check_addr(i);
      next_cycle();
    end
    in_valid = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
